// File: rtl/decode_pkg.sv
// Shared decode constants and the control-bundle type for the MIPS decode stage.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    typedef struct packed {
        logic       regdst;
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [2:0] aluc;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/reg_file_bypass.sv
// Register file, two combinational read ports and one write port with same-cycle
// write-through bypass. Register 0 is hardwired to zero.
module reg_file_bypass #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_COUNT = 32,
    localparam int unsigned RA_W     = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RA_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RA_W-1:0]   raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [RA_W-1:0]   raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs_q [REG_COUNT];
    logic              wr_live;

    assign wr_live = we && (waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_live) begin
            regs_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = regs_q[raddr_a];
        rdata_b = regs_q[raddr_b];
        if (wr_live && waddr == raddr_a) rdata_a = wdata;
        if (wr_live && waddr == raddr_b) rdata_b = wdata;
        if (raddr_a == '0) rdata_a = '0;
        if (raddr_b == '0) rdata_b = '0;
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// MIPS ID stage: register read with bypass, control decode, load-use stall and ID/EX bank.
// Define ID_BRANCH_RESOLVE_EN to resolve beq in ID (branch_taken/branch_target).
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_COUNT = 32,
    localparam int unsigned RA_W     = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       id_instr,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [RA_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_regdst,
    output logic              ex_branch,
    output logic              ex_memread,
    output logic              ex_memtoreg,
    output logic              ex_memwrite,
    output logic              ex_alusrc,
    output logic              ex_regwrite,
    output logic [2:0]        ex_aluc,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [RA_W-1:0]   ex_rs_addr,
    output logic [RA_W-1:0]   ex_rt_addr,
    output logic [RA_W-1:0]   ex_rd_addr,
    output logic              ex_illegal,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target
);

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [RA_W-1:0]   rs_addr;
    logic [RA_W-1:0]   rt_addr;
    logic [RA_W-1:0]   rd_addr;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    ctrl_t             ctrl;
    logic              reads_rt;

    logic              valid_q;
    ctrl_t             ctrl_q;
    logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q, pc4_q;
    logic [RA_W-1:0]   rs_addr_q, rt_addr_q, rd_addr_q;

    assign opcode  = id_instr[31:26];
    assign funct   = id_instr[5:0];
    assign rs_addr = id_instr[21 +: RA_W];
    assign rt_addr = id_instr[16 +: RA_W];
    assign rd_addr = id_instr[11 +: RA_W];
    assign imm_ext = DATA_W'($signed(id_instr[15:0]));

    reg_file_bypass #(
        .DATA_W    (DATA_W),
        .REG_COUNT (REG_COUNT)
    ) u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs_addr),
        .rdata_a (rs_data),
        .raddr_b (rt_addr),
        .rdata_b (rt_data)
    );

    always_comb begin
        ctrl     = CTRL_NOP;
        reads_rt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reads_rt      = 1'b1;
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.aluc = ALUC_ADD;
                    FN_SUB:  ctrl.aluc = ALUC_SUB;
                    FN_AND:  ctrl.aluc = ALUC_AND;
                    FN_OR:   ctrl.aluc = ALUC_OR;
                    FN_SLT:  ctrl.aluc = ALUC_SLT;
                    default: begin
                        ctrl         = CTRL_NOP;
                        ctrl.illegal = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                ctrl.alusrc   = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluc     = ALUC_ADD;
            end
            OP_SW: begin
                reads_rt      = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.aluc     = ALUC_ADD;
            end
            OP_BEQ: begin
                reads_rt  = 1'b1;
                ctrl.aluc = ALUC_SUB;
`ifdef ID_BRANCH_RESOLVE_EN
                ctrl.branch = 1'b0;
`else
                ctrl.branch = 1'b1;
`endif
            end
            OP_ADDI: begin
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluc     = ALUC_ADD;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

    // Load in EX whose destination feeds the ID instruction: one bubble covers it.
    assign stall = valid_q && ctrl_q.memread && (rt_addr_q != '0) && id_valid &&
                   ((rt_addr_q == rs_addr) || (reads_rt && rt_addr_q == rt_addr));

`ifdef ID_BRANCH_RESOLVE_EN
    assign branch_target = id_pc4 + (imm_ext << 2);
    assign branch_taken  = id_valid && (opcode == OP_BEQ) && !stall && !flush &&
                           (rs_data == rt_data);
`else
    assign branch_target = '0;
    assign branch_taken  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= CTRL_NOP;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            pc4_q     <= '0;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            rd_addr_q <= '0;
        end else begin
            if (flush || stall || !id_valid) begin
                valid_q <= 1'b0;
                ctrl_q  <= CTRL_NOP;
            end else begin
                valid_q <= 1'b1;
                ctrl_q  <= ctrl;
            end
            rs_data_q <= rs_data;
            rt_data_q <= rt_data;
            imm_q     <= imm_ext;
            pc4_q     <= id_pc4;
            rs_addr_q <= rs_addr;
            rt_addr_q <= rt_addr;
            rd_addr_q <= rd_addr;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_regdst   = ctrl_q.regdst;
    assign ex_branch   = ctrl_q.branch;
    assign ex_memread  = ctrl_q.memread;
    assign ex_memtoreg = ctrl_q.memtoreg;
    assign ex_memwrite = ctrl_q.memwrite;
    assign ex_alusrc   = ctrl_q.alusrc;
    assign ex_regwrite = ctrl_q.regwrite;
    assign ex_aluc     = ctrl_q.aluc;
    assign ex_illegal  = ctrl_q.illegal;
    assign ex_rs_data  = rs_data_q;
    assign ex_rt_data  = rt_data_q;
    assign ex_imm      = imm_q;
    assign ex_pc4      = pc4_q;
    assign ex_rs_addr  = rs_addr_q;
    assign ex_rt_addr  = rt_addr_q;
    assign ex_rd_addr  = rd_addr_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Scoreboard bench for decode_stage_pipe: directed cases plus randomized instruction stream.
module tb_decode_stage_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] id_instr = '0;
    logic        id_valid = 1'b0;
    logic [31:0] id_pc4 = '0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        stall, ex_valid;
    logic        ex_regdst, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc;
    logic        ex_regwrite, ex_illegal, branch_taken;
    logic [2:0]  ex_aluc;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4, branch_target;
    logic [4:0]  ex_rs_addr, ex_rt_addr, ex_rd_addr;

    decode_stage_pipe dut (
        .clk           (clk),
        .rst           (rst),
        .id_instr      (id_instr),
        .id_valid      (id_valid),
        .id_pc4        (id_pc4),
        .flush         (flush),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .stall         (stall),
        .ex_valid      (ex_valid),
        .ex_regdst     (ex_regdst),
        .ex_branch     (ex_branch),
        .ex_memread    (ex_memread),
        .ex_memtoreg   (ex_memtoreg),
        .ex_memwrite   (ex_memwrite),
        .ex_alusrc     (ex_alusrc),
        .ex_regwrite   (ex_regwrite),
        .ex_aluc       (ex_aluc),
        .ex_rs_data    (ex_rs_data),
        .ex_rt_data    (ex_rt_data),
        .ex_imm        (ex_imm),
        .ex_pc4        (ex_pc4),
        .ex_rs_addr    (ex_rs_addr),
        .ex_rt_addr    (ex_rt_addr),
        .ex_rd_addr    (ex_rd_addr),
        .ex_illegal    (ex_illegal),
        .branch_taken  (branch_taken),
        .branch_target (branch_target)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] ctrl;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } txn_t;

    txn_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [31:0] m_regs [32];
    bit          m_load_valid = 1'b0;
    logic [4:0]  m_load_rt = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Expected control bundle {regdst,branch,memread,memtoreg,memwrite,alusrc,regwrite,aluc,illegal}.
    function automatic logic [10:0] exp_ctrl(input logic [31:0] ins);
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20:   return 11'b1000001_010_0;
                6'h22:   return 11'b1000001_110_0;
                6'h24:   return 11'b1000001_000_0;
                6'h25:   return 11'b1000001_001_0;
                6'h2A:   return 11'b1000001_111_0;
                default: return 11'b0000000_000_1;
            endcase
            6'h23: return 11'b0011011_010_0;
            6'h2B: return 11'b0000110_010_0;
`ifdef ID_BRANCH_RESOLVE_EN
            6'h04: return 11'b0000000_110_0;
`else
            6'h04: return 11'b0100000_110_0;
`endif
            6'h08: return 11'b0000011_010_0;
            default: return 11'b0000000_000_1;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic logic [10:0] dut_ctrl();
        return {ex_regdst, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc,
                ex_regwrite, ex_aluc, ex_illegal};
    endfunction

    // Monitor: every live EX entry must match the oldest expected issue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ex_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_issue: ex_valid 1 with no expected instruction");
                end else begin
                    txn_t e;
                    e = sb_q.pop_front();
                    chk("ex_ctrl", 32'(dut_ctrl()), 32'(e.ctrl));
                    chk("ex_rs_data", ex_rs_data, e.rs_data);
                    chk("ex_rt_data", ex_rt_data, e.rt_data);
                    chk("ex_imm", ex_imm, e.imm);
                    chk("ex_pc4", ex_pc4, e.pc4);
                    chk("ex_addrs", 32'({ex_rs_addr, ex_rt_addr, ex_rd_addr}),
                        32'({e.rs, e.rt, e.rd}));
                end
            end else begin
                chk("bubble_ctrl", 32'({ex_valid, dut_ctrl()}), 32'd0);
            end
        end
    end

    // One ID cycle: drive, check stall/branch against the model, record expected issue.
    task automatic cycle(input logic [31:0] ins, input bit vld, input bit fl, input bit we,
                         input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc4,
                         output bit stalled);
        logic [5:0]  op;
        logic [4:0]  rs, rt;
        logic [31:0] rs_v, rt_v;
        bit          reads_rt, exp_stall;
        txn_t        t;
        id_instr = ins; id_valid = vld; flush = fl;
        wb_en = we; wb_addr = wa; wb_data = wd; id_pc4 = pc4;
        #1;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
        reads_rt  = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        exp_stall = m_load_valid && m_load_rt != 5'd0 && vld &&
                    (m_load_rt == rs || (reads_rt && m_load_rt == rt));
        chk("stall", 32'(stall), 32'(exp_stall));
        rs_v = m_read(rs, we, wa, wd);
        rt_v = m_read(rt, we, wa, wd);
`ifdef ID_BRANCH_RESOLVE_EN
        chk("branch_taken", 32'(branch_taken),
            32'(vld && op == 6'h04 && !exp_stall && !fl && rs_v == rt_v));
        chk("branch_target", branch_target, pc4 + 32'($signed(ins[15:0])) * 32'd4);
`else
        chk("branch_taken", 32'(branch_taken), 32'd0);
        chk("branch_target", branch_target, 32'd0);
`endif
        if (vld && !fl && !exp_stall) begin
            t.ctrl = exp_ctrl(ins);
            t.rs_data = rs_v; t.rt_data = rt_v;
            t.imm = 32'($signed(ins[15:0])); t.pc4 = pc4;
            t.rs = rs; t.rt = rt; t.rd = ins[15:11];
            sb_q.push_back(t);
            m_load_valid = (op == 6'h23);
            m_load_rt = rt;
        end else begin
            m_load_valid = 1'b0;
        end
        if (we && wa != 5'd0) m_regs[wa] = wd;
        stalled = exp_stall;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc4, output int nstall);
        bit st;
        nstall = 0;
        do begin
            cycle(ins, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, pc4, st);
            if (st) nstall++;
        end while (st && nstall < 4);
    endtask

    task automatic idle(input int n);
        bit st;
        for (int i = 0; i < n; i++) cycle(32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, st);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_load_valid = 1'b0;
    endfunction

    task automatic do_reset();
        rst = 1'b1; id_valid = 1'b0; flush = 1'b0; wb_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [5:0] fns [5];
        logic [4:0] rs, rt, rd;
        logic [15:0] imm;
        int sel;
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        sel = int'($urandom_range(0, 9));
        case (sel)
            0, 1, 2: return rtype(rs, rt, rd, fns[$urandom_range(0, 4)]);
            3:       return {6'h00, rs, rt, rd, 5'($urandom), 6'($urandom)};
            4, 5:    return itype(6'h23, rs, rt, imm);
            6:       return itype(6'h2B, rs, rt, imm);
            7:       return itype(6'h04, rs, rt, imm);
            8:       return itype(6'h08, rs, rt, imm);
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ns;
        bit          st;
        logic [31:0] cur;
        model_reset();
        do_reset();
        chk("reset_ex_valid", 32'(ex_valid), 32'd0);
        chk("reset_ctrl", 32'(dut_ctrl()), 32'd0);
        chk("reset_data", ex_rs_data | ex_rt_data | ex_imm | ex_pc4, 32'd0);
        chk("reset_addrs", 32'({ex_rs_addr, ex_rt_addr, ex_rd_addr}), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        mon_en = 1'b1;

        // Register file contents are cleared by reset.
        cycle(32'd0, 1'b0, 1'b0, 1'b1, 5'd7, 32'hA5A5_5A5A, 32'd0, st);
        do_reset();
        issue(rtype(5'd7, 5'd7, 5'd1, 6'h20), 32'h10, ns);

        // Same-cycle write-through bypass.
        cycle(rtype(5'd5, 5'd0, 5'd3, 6'h20), 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'h14, st);
        issue(rtype(5'd5, 5'd5, 5'd4, 6'h24), 32'h18, ns);

        // Writes to $0 are dropped.
        cycle(rtype(5'd0, 5'd0, 5'd1, 6'h25), 1'b1, 1'b0, 1'b1, 5'd0, 32'h1234_5678, 32'h1C, st);
        issue(rtype(5'd0, 5'd0, 5'd1, 6'h25), 32'h20, ns);

        // Load-use: one stall cycle then the dependent sub issues.
        issue(itype(6'h23, 5'd2, 5'd8, 16'd4), 32'h24, ns);
        issue(rtype(5'd8, 5'd1, 5'd9, 6'h22), 32'h28, ns);
        chk("load_use_stall_len", 32'(ns), 32'd1);

        // Flush while stalled with sw in ID kills it.
        issue(itype(6'h23, 5'd2, 5'd8, 16'd0), 32'h2C, ns);
        cycle(itype(6'h2B, 5'd8, 5'd8, 16'd0), 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 32'h30, st);
        chk("flush_during_stall", 32'(st), 32'd1);
        idle(1);

        // Illegal opcode and beq $4,$4,-1.
        issue(itype(6'h3F, 5'd3, 5'd4, 16'h1234), 32'h34, ns);
        issue(itype(6'h04, 5'd4, 5'd4, 16'hFFFF), 32'h100, ns);

        // Reset while a load-use stall is pending.
        issue(itype(6'h23, 5'd1, 5'd6, 16'd8), 32'h40, ns);
        id_instr = rtype(5'd6, 5'd2, 5'd3, 6'h20); id_valid = 1'b1; rst = 1'b1;
        #1;
        chk("stall_before_reset", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("stall_after_reset", 32'(stall), 32'd0);
        model_reset();
        idle(1);

        // Randomized stream; a stalled instruction is held in ID unless flushed.
        cur = gen_instr();
        for (int i = 0; i < 600; i++) begin
            bit vld, fl;
            vld = ($urandom_range(0, 9) != 0);
            fl  = ($urandom_range(0, 11) == 0);
            cycle(cur, vld, fl, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  $urandom, $urandom, st);
            if (!(st && !fl)) cur = gen_instr();
        end

        idle(3);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
